// File: rtl/gpio_seq.sv
`timescale 1ns/1ps
// gpio_seq: Wishbone-loaded command FIFO replayed as timed set/clear writes to a GPIO controller.
// Optional build macro GPIO_SEQ_LOOP_EN adds a LOOP control bit for repeating, non-destructive playback.
module gpio_seq #(
    parameter int LGFIFO = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_gp_cyc,
    output logic        o_gp_stb,
    output logic        o_gp_we,
    output logic [31:0] o_gp_data,
    output logic [3:0]  o_gp_sel,
    input  logic        i_gp_stall,
    input  logic        i_gp_ack,
    input  logic        i_gp_err,
    output logic        o_int
);

    localparam int              DEPTH   = 1 << LGFIFO;
    localparam logic [LGFIFO:0] PTR_ONE = {{LGFIFO{1'b0}}, 1'b1};
    localparam logic [1:0]      S_IDLE  = 2'd0;
    localparam logic [1:0]      S_WRITE = 2'd1;
    localparam logic [1:0]      S_WAIT  = 2'd2;

    logic [31:0]     mem_q [DEPTH];
    logic [LGFIFO:0] wr_q, wr_d, rd_q, rd_d, fill;
    logic [1:0]      state_q, state_d;
    logic [15:0]     delay_q, delay_d, cnt_q, cnt_d;
    logic [31:0]     gpd_q, gpd_d;
    logic            cyc_q, cyc_d, stb_q, stb_d;
    logic            en_q, en_d, ovf_q, ovf_d, err_q, err_d;
    logic            flush_pend_q, flush_pend_d;
    logic            ack_q, int_q, int_d;
    logic [31:0]     rdata_q, rdata_d, status;
    logic            wb_wr, ctl_wr, push_req, flush;
    logic            empty, full, take, adv_rd, push_ok, loop_on, gp_fault;
    logic [31:0]     head;
    logic            unused_sel;

    assign unused_sel = ^i_wb_sel;

    assign wb_wr    = i_wb_cyc & i_wb_stb & i_wb_we;
    assign ctl_wr   = wb_wr & ~i_wb_addr;
    assign push_req = wb_wr & i_wb_addr;
    assign flush    = ctl_wr & i_wb_data[1];

    assign fill    = wr_q - rd_q;
    assign empty   = (fill == '0);
    assign full    = fill[LGFIFO];
    assign take    = (state_q == S_IDLE) & en_q & ~empty & ~flush;
    assign adv_rd  = take & ~loop_on;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign push_ok = push_req & (~full | adv_rd);

`ifdef GPIO_SEQ_LOOP_EN
    logic            loop_q, loop_d;
    logic [LGFIFO:0] play_q, play_d, play_inc;

    assign loop_on  = loop_q;
    assign play_inc = play_q + PTR_ONE;
    assign head     = loop_q ? mem_q[play_q[LGFIFO-1:0]] : mem_q[rd_q[LGFIFO-1:0]];

    // Outside loop mode the play index shadows the read pointer, so enabling LOOP starts at the head.
    always_comb begin
        loop_d = ctl_wr ? i_wb_data[2] : loop_q;
        play_d = play_q;
        if (!loop_q || flush) begin
            play_d = rd_d;
        end else if (take) begin
            play_d = (play_inc == wr_q) ? rd_q : play_inc;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            loop_q <= 1'b0;
            play_q <= '0;
        end else begin
            loop_q <= loop_d;
            play_q <= play_d;
        end
    end
`else
    assign loop_on = 1'b0;
    assign head    = mem_q[rd_q[LGFIFO-1:0]];
`endif

    always_comb begin
        status          = '0;
        status[0]       = en_q;
        status[1]       = empty;
        status[2]       = full;
        status[3]       = ovf_q;
        status[4]       = err_q;
        status[5]       = (state_q != S_IDLE);
        status[LGFIFO+8:8] = fill;
    end

    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        cnt_d        = cnt_q;
        gpd_d        = gpd_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        gp_fault     = 1'b0;
        flush_pend_d = flush_pend_q | flush;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_WRITE;
                    delay_d = head[31:16];
                    gpd_d   = {8'h00, head[15:8], 8'h00, head[7:0]};
                end
            end
            S_WRITE: begin
                if (!cyc_q) begin
                    if (flush_pend_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        cyc_d = 1'b1;
                        stb_d = 1'b1;
                    end
                end else begin
                    if (stb_q && !i_gp_stall) begin
                        stb_d = 1'b0;
                    end
                    if (i_gp_ack || i_gp_err) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        if (i_gp_err) begin
                            gp_fault = 1'b1;
                            state_d  = S_IDLE;
                        end else if (delay_q != 16'd0 && !(flush_pend_q || flush)) begin
                            state_d = S_WAIT;
                            cnt_d   = delay_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT: begin
                // Counter runs D edges, so D adds exactly D cycles between writes.
                if (flush_pend_q || flush || cnt_q <= 16'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase

        if (state_d == S_IDLE) begin
            flush_pend_d = 1'b0;
        end
    end

    always_comb begin
        wr_d = wr_q + (push_ok ? PTR_ONE : '0);
        rd_d = flush ? wr_q : (rd_q + (adv_rd ? PTR_ONE : '0));

        en_d = ctl_wr ? i_wb_data[0] : en_q;
        if (gp_fault) begin
            en_d = 1'b0;
        end

        err_d = err_q;
        ovf_d = ovf_q;
        if (ctl_wr && i_wb_data[3]) begin
            err_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (gp_fault) begin
            err_d = 1'b1;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        int_d   = en_q & empty & (state_q == S_IDLE);
        rdata_d = (i_wb_cyc && i_wb_stb && !i_wb_we && !i_wb_addr) ? status : 32'h0;
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_q[LGFIFO-1:0]] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_q         <= '0;
            rd_q         <= '0;
            state_q      <= S_IDLE;
            delay_q      <= '0;
            cnt_q        <= '0;
            gpd_q        <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            en_q         <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            ack_q        <= 1'b0;
            int_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            state_q      <= state_d;
            delay_q      <= delay_d;
            cnt_q        <= cnt_d;
            gpd_q        <= gpd_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            en_q         <= en_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            ack_q        <= i_wb_stb;
            int_q        <= int_d;
            rdata_q      <= rdata_d;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_gp_cyc   = cyc_q;
    assign o_gp_stb   = stb_q;
    assign o_gp_we    = 1'b1;
    assign o_gp_data  = gpd_q;
    assign o_gp_sel   = 4'hf;
    assign o_int      = int_q;

endmodule

// File: tb/tb_gpio_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for gpio_seq: expected GPIO writes and status reads are queued at issue time
// and popped by independent bus monitors.
module tb_gpio_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0, i_wb_addr = 1'b0;
    logic [31:0] i_wb_data = 32'h0;
    logic [3:0]  i_wb_sel = 4'hf;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_gp_cyc, o_gp_stb, o_gp_we;
    logic [31:0] o_gp_data;
    logic [3:0]  o_gp_sel;
    logic        i_gp_stall = 1'b0, i_gp_ack = 1'b0, i_gp_err = 1'b0;
    logic        o_int;

    gpio_seq #(.LGFIFO(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .o_gp_cyc(o_gp_cyc), .o_gp_stb(o_gp_stb), .o_gp_we(o_gp_we),
        .o_gp_data(o_gp_data), .o_gp_sel(o_gp_sel),
        .i_gp_stall(i_gp_stall), .i_gp_ack(i_gp_ack), .i_gp_err(i_gp_err),
        .o_int(o_int)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          cyc_cnt = 0;
    int          nwr = 0;
    int          err_at = -1;
    int          stall_left = 0;
    int          rise_e [64];
    int          ack_e  [64];
    int          last_edge = 0;
    logic [31:0] gp_exp [$];
    bit          wb_isrd [$];
    logic [31:0] wb_exp [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    // GPIO slave: ack/err latency 1, optional stall, compares each accepted write.
    initial begin
        bit          ack_nx = 1'b0, err_nx = 1'b0, prev_stb = 1'b0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            i_gp_ack = ack_nx;
            i_gp_err = err_nx;
            ack_nx   = 1'b0;
            err_nx   = 1'b0;
            if (o_gp_stb && !prev_stb && nwr < 64) rise_e[nwr] = cyc_cnt;
            prev_stb = o_gp_stb;
            if (o_gp_stb) begin
                if (stall_left > 0) begin
                    i_gp_stall = 1'b1;
                    stall_left--;
                end else begin
                    i_gp_stall = 1'b0;
                    if (nwr < 64) ack_e[nwr] = cyc_cnt + 2;
                    if (gp_exp.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL gp_write: unexpected write 0x%08h, want none", o_gp_data);
                    end else begin
                        e = gp_exp.pop_front();
                        check("gp_data", o_gp_data, e);
                    end
                    if (nwr == err_at) err_nx = 1'b1;
                    else ack_nx = 1'b1;
                    nwr++;
                end
            end else begin
                i_gp_stall = 1'b0;
            end
        end
    end

    // Slave-port monitor: every ack pops one issued transaction; reads compare data.
    initial begin
        bit          isr;
        logic [31:0] ex;
        forever begin
            @(negedge clk);
            if (o_wb_ack) begin
                if (wb_isrd.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_ack: ack with no transaction, want none");
                end else begin
                    isr = wb_isrd.pop_front();
                    ex  = wb_exp.pop_front();
                    if (isr) check("wb_rdata", o_wb_data, ex);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wb_cycle(input logic we, input logic adr, input logic [31:0] dat, input logic [31:0] exp);
        @(negedge clk);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = adr;
        i_wb_data = dat;
        wb_isrd.push_back(!we);
        wb_exp.push_back(exp);
        last_edge = cyc_cnt + 1;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic ctl(input logic [31:0] v);
        wb_cycle(1'b1, 1'b0, v, 32'h0);
    endtask

    task automatic push(input logic [31:0] v);
        wb_cycle(1'b1, 1'b1, v, 32'h0);
    endtask

    task automatic rd_status(input logic [31:0] exp);
        wb_cycle(1'b0, 1'b0, 32'h0, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n = 0;
        while (nwr < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (nwr < target) begin
            n_bad++;
            $display("FAIL %s: timeout with %0d writes, want %0d", name, nwr, target);
        end
    endtask

    initial begin
        int b, p, a, n;

        // Reset state
        idle(3);
        check("rst_gp_cyc", 32'(o_gp_cyc), 32'h0);
        check("rst_gp_stb", 32'(o_gp_stb), 32'h0);
        check("rst_gp_data", o_gp_data, 32'h0);
        check("rst_wb_ack", 32'(o_wb_ack), 32'h0);
        check("rst_wb_data", o_wb_data, 32'h0);
        check("rst_int", 32'(o_int), 32'h0);
        rst_n = 1'b1;
        idle(2);
        rd_status(32'h0000_0002);
        wb_cycle(1'b0, 1'b1, 32'h0, 32'h0);

        // Single command, D=0
        ctl(32'h1);
        idle(2);
        check("int_idle_en", 32'(o_int), 32'h1);
        gp_exp.push_back(32'h0001_0001);
        push(32'h0000_0101);
        p = last_edge;
        wait_writes(1, 50, "single");
        check("push_to_stb", 32'(rise_e[0]), 32'(p + 2));
        a = ack_e[0];
        while (cyc_cnt < a) @(negedge clk);
        check("int_at_ack", 32'(o_int), 32'h0);
        @(negedge clk);
        check("int_after_ack", 32'(o_int), 32'h1);

        // Stalled first write with D=3, then D=0 command
        idle(3);
        b = nwr;
        stall_left = 2;
        gp_exp.push_back(32'h0001_0001);
        gp_exp.push_back(32'h0001_0000);
        push(32'h0003_0101);
        push(32'h0000_0100);
        wait_writes(b + 2, 100, "delay3");
        check("d3_spacing", 32'(rise_e[b+1] - ack_e[b]), 32'd5);

        // Overflow: 17 pushes with EN=0, then enable and clear OVF
        idle(3);
        ctl(32'h0);
        idle(3);
        b = nwr;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) gp_exp.push_back({8'h00, 8'hFF, 8'h00, 8'(i)});
            push({16'h0000, 8'hFF, 8'(i)});
        end
        idle(2);
        rd_status(32'h0000_100C);
        ctl(32'h9);
        wait_writes(b + 16, 400, "drain16");
        check("d0_spacing", 32'(rise_e[b+1] - ack_e[b]), 32'd2);
        idle(5);
        rd_status(32'h0000_0003);

        // Bus error on the second of three commands
        b = nwr;
        err_at = b + 1;
        gp_exp.push_back(32'h0002_0002);
        gp_exp.push_back(32'h0002_0000);
        push(32'h0000_0202);
        push(32'h0000_0200);
        push(32'h0000_0203);
        wait_writes(b + 2, 100, "err_seq");
        idle(20);
        check("no_write_after_err", 32'(nwr), 32'(b + 2));
        rd_status(32'h0000_0110);
        err_at = -1;
        ctl(32'h8);
        ctl(32'h2);
        idle(2);
        rd_status(32'h0000_0002);

        // Asynchronous reset while a write is outstanding
        ctl(32'h1);
        stall_left = 1000;
        push(32'h0000_0101);
        n = 0;
        while (!o_gp_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stb_before_reset", 32'(o_gp_stb), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_cyc_stb", {30'h0, o_gp_cyc, o_gp_stb}, 32'h0);
        stall_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd_status(32'h0000_0002);

`ifdef GPIO_SEQ_LOOP_EN
        // Looped replay A,B,A,B then EN=0 ends after the current command
        b = nwr;
        gp_exp.push_back(32'h000F_0005);
        gp_exp.push_back(32'h00F0_0050);
        gp_exp.push_back(32'h000F_0005);
        gp_exp.push_back(32'h00F0_0050);
        push(32'h0004_0F05);
        push(32'h0004_F050);
        ctl(32'h5);
        wait_writes(b + 2, 200, "loop_first");
        check("loop_int_low", 32'(o_int), 32'h0);
        check("loop_spacing", 32'(rise_e[b+1] - ack_e[b]), 32'd6);
        wait_writes(b + 4, 200, "loop_second");
        ctl(32'h4);
        idle(40);
        check("loop_stop", 32'(nwr), 32'(b + 4));
        rd_status(32'h0000_0200);
`endif

        idle(5);
        n_cmp++;
        if (gp_exp.size() != 0) begin
            n_bad++;
            $display("FAIL gp_missing: %0d expected writes not seen, want 0", gp_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
